// File: rtl/rx_eth100_sync.sv
// MII 100 Mbit/s receiver running on System_Clock: oversamples the PHY pins, strips
// preamble/SFD, assembles bytes, and reports CRC-32, alignment and length status per frame.
module rx_eth100_sync #(
   parameter int MIN_FRAME_BYTES = 64,
   parameter int MAX_FRAME_BYTES = 1518
) (
   input  logic        System_Clock,
   input  logic        Reset_n,
   input  logic        MII_Rx_CLK,
   input  logic        MII_Rx_DV,
   input  logic        MII_Rx_Er,
   input  logic [3:0]  MII_Rx_Data,
   output logic [7:0]  Rx_Data,
   output logic        Rx_Data_Strob,
   output logic        Rx_Frame_Start,
   output logic        Rx_Frame_End,
   output logic [4:0]  Rx_Status,
   output logic [10:0] Rx_Byte_Count,
   output logic        Rx_In_Progress
);

   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [10:0] MIN_CNT     = 11'(MIN_FRAME_BYTES);
   localparam logic [10:0] MAX_CNT     = 11'(MAX_FRAME_BYTES);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 4; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      return (v == 11'h7FF) ? v : v + 11'd1;
   endfunction

   logic       rx_clk_p0, rx_clk_p1, rx_clk_p2;
   logic       dv_p0, dv_p1, er_p0, er_p1;
   logic [3:0] nib_p0, nib_p1;
   logic       tick;

   state_t      state, state_nx;
   logic        seen5, seen5_nx, phase, phase_nx;
   logic [3:0]  low_nib, low_nib_nx;
   logic [31:0] crc, crc_nx;
   logic [7:0]  data_nx;
   logic        strobe_nx, start_nx, end_nx;
   logic [4:0]  status_nx;
   logic [10:0] count_nx;

   // Stage p0/p1: synchronizer; p2 on the clock path only, for falling-edge detection
   always_ff @(posedge System_Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         rx_clk_p0 <= 1'b0;
         rx_clk_p1 <= 1'b0;
         rx_clk_p2 <= 1'b0;
         dv_p0     <= 1'b0;
         dv_p1     <= 1'b0;
         er_p0     <= 1'b0;
         er_p1     <= 1'b0;
         nib_p0    <= 4'h0;
         nib_p1    <= 4'h0;
      end else begin
         rx_clk_p0 <= MII_Rx_CLK;
         rx_clk_p1 <= rx_clk_p0;
         rx_clk_p2 <= rx_clk_p1;
         dv_p0     <= MII_Rx_DV;
         dv_p1     <= dv_p0;
         er_p0     <= MII_Rx_Er;
         er_p1     <= er_p0;
         nib_p0    <= MII_Rx_Data;
         nib_p1    <= nib_p0;
      end
   end

   assign tick = rx_clk_p2 & ~rx_clk_p1;

   always_comb begin
      state_nx   = state;
      seen5_nx   = seen5;
      phase_nx   = phase;
      low_nib_nx = low_nib;
      crc_nx     = crc;
      data_nx    = Rx_Data;
      strobe_nx  = 1'b0;
      start_nx   = 1'b0;
      end_nx     = 1'b0;
      status_nx  = Rx_Status;
      count_nx   = Rx_Byte_Count;
      if (tick) begin
         case (state)
            IDLE: begin
               if (dv_p1) begin
                  state_nx = PREAMBLE;
                  seen5_nx = 1'b0;
               end
            end
            PREAMBLE: begin
               if (!dv_p1) begin
                  state_nx = IDLE;
               end else if (nib_p1 == 4'h5) begin
                  seen5_nx = 1'b1;
               end else if (nib_p1 == 4'hD && seen5) begin
                  state_nx  = DATA;
                  crc_nx    = 32'hFFFFFFFF;
                  phase_nx  = 1'b0;
                  count_nx  = 11'd0;
                  status_nx = 5'd0;
               end else begin
                  state_nx = DROP;
               end
            end
            DATA: begin
               if (er_p1) status_nx[4] = 1'b1;
               if (dv_p1) begin
                  crc_nx = crc_nib(crc, nib_p1);
                  if (!phase) begin
                     low_nib_nx = nib_p1;
                     phase_nx   = 1'b1;
                  end else begin
                     phase_nx = 1'b0;
                     // Past the maximum the byte is dropped but still covered by the CRC
                     if (Rx_Byte_Count >= MAX_CNT) begin
                        status_nx[3] = 1'b1;
                     end else begin
                        strobe_nx = 1'b1;
                        start_nx  = (Rx_Byte_Count == 11'd0);
                        data_nx   = {nib_p1, low_nib};
                        count_nx  = sat_inc(Rx_Byte_Count);
                     end
                  end
               end else begin
                  end_nx       = 1'b1;
                  status_nx[0] = (crc == CRC_RESIDUE);
                  status_nx[1] = phase;
                  status_nx[2] = (Rx_Byte_Count < MIN_CNT);
                  phase_nx     = 1'b0;
                  state_nx     = IDLE;
               end
            end
            DROP: begin
               if (!dv_p1) state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   // Stage: registered FSM state and outputs
   always_ff @(posedge System_Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state          <= IDLE;
         seen5          <= 1'b0;
         phase          <= 1'b0;
         low_nib        <= 4'h0;
         crc            <= 32'hFFFFFFFF;
         Rx_Data        <= 8'h00;
         Rx_Data_Strob  <= 1'b0;
         Rx_Frame_Start <= 1'b0;
         Rx_Frame_End   <= 1'b0;
         Rx_Status      <= 5'd0;
         Rx_Byte_Count  <= 11'd0;
      end else begin
         state          <= state_nx;
         seen5          <= seen5_nx;
         phase          <= phase_nx;
         low_nib        <= low_nib_nx;
         crc            <= crc_nx;
         Rx_Data        <= data_nx;
         Rx_Data_Strob  <= strobe_nx;
         Rx_Frame_Start <= start_nx;
         Rx_Frame_End   <= end_nx;
         Rx_Status      <= status_nx;
         Rx_Byte_Count  <= count_nx;
      end
   end

   assign Rx_In_Progress = (state == DATA);

endmodule

// File: doc/rx_eth100_sync.md
# rx_eth100_sync

MII 100 Mbit/s Ethernet receiver clocked entirely on System_Clock. It oversamples the PHY's MII_Rx_CLK, MII_Rx_DV, MII_Rx_Er and MII_Rx_Data, strips the preamble and SFD, and assembles nibbles into bytes. It checks the frame's CRC-32 and length and delivers bytes as 1-cycle strobes plus a per-frame status word. It is the receive-side counterpart of the MII transmitter and sits between the PHY pins and the packet-parsing logic.

## Interface
- MIN_FRAME_BYTES, 64: minimum frame length (destination address through FCS); shorter frames flag Short.
- MAX_FRAME_BYTES, 1518: maximum frame length; longer frames flag Long and are truncated.
- System_Clock  in  1  system clock, ≥ 4× MII_Rx_CLK (≥ 100 MHz).
- Reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- MII_Rx_CLK  in  1  PHY receive clock (25 MHz), asynchronous to System_Clock.
- MII_Rx_DV  in  1  PHY receive data valid.
- MII_Rx_Er  in  1  PHY receive error.
- MII_Rx_Data  in  4  receive nibble; bit 0 is the first bit on the wire.
- Rx_Data  out  8  received byte; the first nibble is in bits [3:0].
- Rx_Data_Strob  out  1  1-cycle strobe; Rx_Data is valid in the same cycle.
- Rx_Frame_Start  out  1  1-cycle strobe, coincident with the Rx_Data_Strob of the first byte after the SFD.
- Rx_Frame_End  out  1  1-cycle strobe; Rx_Status is valid from this cycle onward.
- Rx_Status  out  5  [0] CRC_OK, [1] Align, [2] Short, [3] Long, [4] Rx_Er seen.
- Rx_Byte_Count  out  11  bytes in the current or last frame, FCS included; saturates at 2047.
- Rx_In_Progress  out  1  high in state DATA.

## Operation
- Input capture:
  - All four MII inputs pass through a 2-flop synchronizer.
  - A third stage on the clock path detects the falling edge of the synchronized MII_Rx_CLK.
  - DV, Er and Data are taken from the stage aligned with that edge.
  - Sampling at the falling edge places the sample half a period after the PHY's launch edge.
  - All logic below advances only on a detected falling edge ("nibble tick").
- FSM states: IDLE, PREAMBLE, DATA, DROP.
  - IDLE: DV=1 → PREAMBLE.
  - PREAMBLE:
    - nibble 0x5 → stay.
    - nibble 0xD after at least one 0x5 → DATA. The CRC is preset to 0xFFFFFFFF, and the nibble phase, byte count and status are cleared.
    - Any other nibble, or 0xD with no preceding 0x5 → DROP.
    - DV=0 → IDLE; no strobes.
  - DATA, DV=1:
    - Even-phase nibble → low half of the byte.
    - Odd-phase nibble → byte complete: Rx_Data_Strob, count+1.
    - Rx_Frame_Start accompanies byte 1.
    - Once the count reaches MAX_FRAME_BYTES: set Long, suppress further strobes, stay in DATA until DV=0.
    - Er=1 on any tick → set status bit [4].
  - DATA, DV=0:
    - Rx_Frame_End.
    - Align = odd nibble pending; the partial nibble is discarded and not strobed.
    - Short = count < MIN_FRAME_BYTES.
    - CRC_OK = CRC register == 0xDEBB20E3.
    - → IDLE.
  - DROP: wait for DV=0 → IDLE. No strobes, no Frame_End.
- CRC: reflected CRC-32, polynomial 0xEDB88320.
  - Init all-ones, updated 4 bits per nibble tick, LSB first.
  - Covers every nibble in DATA, FCS included; a good frame leaves residue 0xDEBB20E3.
  - Nibbles are still CRC'd after truncation.
- Rx_Status and Rx_Byte_Count hold their values until the next SFD is accepted.
- Timing constraints on the MII pins are out of scope.

## Timing
- Reset values of all outputs: Rx_Data=0x00, strobes=0, Rx_Status=0, Rx_Byte_Count=0, Rx_In_Progress=0. FSM=IDLE, synchronizers cleared.
- Latency: falling edge of MII_Rx_CLK → nibble tick is 3 System_Clock cycles. Tick completing a byte → Rx_Data_Strob is 1 cycle later (registered).
- Byte strobes are at least 8 System_Clock cycles apart at 100 MHz. No backpressure: the consumer must accept every strobe.
- Rx_Frame_End comes 1 cycle after the tick at which DV=0 is sampled. It never coincides with Rx_Data_Strob.
- Reset_n asserted mid-frame: immediate return to IDLE with no Frame_End. After release, a frame already in progress is ignored: DV is seen high in PREAMBLE with a non-preamble nibble → DROP.
- Simultaneous DV=0 and odd phase: Frame_End with Align=1. The last complete byte was already strobed.

## Test plan
- Good frame: 7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS → 64 strobes, data matches, Frame_Start on byte 0x00, Rx_Status=5'b00001, Rx_Byte_Count=64.
- Same frame with byte 10 corrupted to 0xFF → 64 strobes, Rx_Status=5'b00000.
- 40-byte frame with correct FCS → 40 strobes, Rx_Status=5'b00101, count=40. Then the good frame with one extra nibble before DV drops → 64 strobes, Align=1, CRC_OK=0.
- 1600-byte frame → exactly 1518 strobes, Long=1, one Frame_End after DV falls. Rx_Er pulsed in payload of a good frame → bit [4]=1, CRC_OK=1.
- Preamble 0x5,0x5,0x3 followed by a full frame → no strobes, no Frame_End. DV low then a good frame → normal reception.
- Reset_n pulsed at byte 30 of a good frame → all outputs at reset values, no Frame_End. The next complete frame is received with Rx_Status=5'b00001.
